// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator operand/operation sequencer.
//   - phase/state encodings (ENTER_A..ERR, visible on the LEDs)
//   - operation codes driven to the arithmetic units
//   - display constant shown while in the error state
package calc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_START   = 3'd2,
    ST_BUSY    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // MSB: fixed(1)/floating(0); LSB: multiply(1)/add(0)
  localparam logic [1:0] OP_FL_ADD = 2'b00;
  localparam logic [1:0] OP_FL_MUL = 2'b01;
  localparam logic [1:0] OP_FI_ADD = 2'b10;
  localparam logic [1:0] OP_FI_MUL = 2'b11;

  localparam logic [15:0] ERR_DISP = 16'hEEEE;

endpackage

// File: rtl/calc_sequencer_btn_priority_enc.sv
// Button priority encoder.
// Folds the four debounced button pulses into a single "some button" strobe
// and the op code of the winning button. Priority: fim > fia > flm > fla.
// Ports:
//   btn_fla, btn_flm, btn_fia, btn_fim : debounced single-cycle pulses
//   any_btn                            : OR of all four pulses
//   code                               : op code of the highest-priority pulse
module btn_priority_enc
  import calc_sequencer_pkg::*;
(
  input  logic       btn_fla,
  input  logic       btn_flm,
  input  logic       btn_fia,
  input  logic       btn_fim,
  output logic       any_btn,
  output logic [1:0] code
);

  always_comb begin
    any_btn = btn_fla | btn_flm | btn_fia | btn_fim;
    code    = OP_FL_ADD;
    if (btn_fim)      code = OP_FI_MUL;
    else if (btn_fia) code = OP_FI_ADD;
    else if (btn_flm) code = OP_FL_MUL;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator operand-entry and operation sequencer.
// Captures operand A then operand B from the switches on button presses (the
// button confirming B picks the operation), pulses start for one cycle, waits
// for done with a bounded timeout, then holds the result for display.
// Ports:
//   clk, rst            : clock; asynchronous active-high reset
//   sw                  : switch value, operand source
//   btn_fla/flm/fia/fim : debounced button pulses
//   done, result_in     : handshake and result from the selected arithmetic unit
//   num1, num2, op      : latched operands and operation code
//   start               : one-cycle launch pulse
//   disp                : value for LEDs/seven-segment display (combinational)
//   phase               : current state encoding
//   err                 : timeout flag, high while in the error state
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_fla,
  input  logic              btn_flm,
  input  logic              btn_fia,
  input  logic              btn_fim,
  input  logic              done,
  input  logic [DATA_W-1:0] result_in,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [1:0]        op,
  output logic              start,
  output logic [DATA_W-1:0] disp,
  output logic [2:0]        phase,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  logic [DATA_W-1:0] result;
  logic [CNT_W-1:0]  count;
  logic              any_btn;
  logic [1:0]        btn_code;

  btn_priority_enc u_btn_priority_enc (
    .btn_fla (btn_fla),
    .btn_flm (btn_flm),
    .btn_fia (btn_fia),
    .btn_fim (btn_fim),
    .any_btn (any_btn),
    .code    (btn_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ENTER_A;
      num1   <= '0;
      num2   <= '0;
      op     <= OP_FL_ADD;
      start  <= 1'b0;
      result <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      // start is high only for the single cycle spent in START
      start <= 1'b0;
      case (state)
        ST_ENTER_A: begin
          if (any_btn) begin
            num1  <= sw;
            state <= ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (any_btn) begin
            num2  <= sw;
            op    <= btn_code;
            start <= 1'b1;
            state <= ST_START;
          end
        end
        ST_START: begin
          count <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (done) begin
            result <= result_in;
            state  <= ST_SHOW;
          end else if (count == CNT_LAST) begin
            err   <= 1'b1;
            state <= ST_ERR;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_SHOW: begin
          if (any_btn) state <= ST_ENTER_A;
        end
        ST_ERR: begin
          if (any_btn) begin
            err   <= 1'b0;
            state <= ST_ENTER_A;
          end
        end
        default: begin
          // unused encodings 6/7
          err   <= 1'b0;
          state <= ST_ENTER_A;
        end
      endcase
    end
  end

  assign phase = state;

  always_comb begin
    case (state)
      ST_SHOW: disp = result;
      ST_ERR:  disp = DATA_W'(ERR_DISP);
      default: disp = sw;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic        btn_fla, btn_flm, btn_fia, btn_fim;
  logic        done;
  logic [15:0] result_in;
  logic [15:0] num1, num2, disp;
  logic [1:0]  op;
  logic        start, err;
  logic [2:0]  phase;

  int checks = 0;
  int errors = 0;

  calc_sequencer #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn_fla   (btn_fla),
    .btn_flm   (btn_flm),
    .btn_fia   (btn_fia),
    .btn_fim   (btn_fim),
    .done      (done),
    .result_in (result_in),
    .num1      (num1),
    .num2      (num2),
    .op        (op),
    .start     (start),
    .disp      (disp),
    .phase     (phase),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic btns(input logic [3:0] b); // {fim, fia, flm, fla}
    {btn_fim, btn_fia, btn_flm, btn_fla} = b;
  endtask

  initial begin
    rst = 1'b1; sw = 16'h0000; btns(4'b0000); done = 1'b0; result_in = 16'h0000;
    tick(); tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_num1", 32'(num1), 32'h0);
    chk("rst_num2", 32'(num2), 32'h0);
    chk("rst_op", 32'(op), 32'h0);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst = 1'b0;

    // Basic entry: A via fla, B via fim
    done = 1'b1; result_in = 16'hABCD;
    sw = 16'h1234; btns(4'b0001);
    tick(); btns(4'b0000);
    chk("a_phase", 32'(phase), 32'd1);
    chk("a_num1", 32'(num1), 32'h1234);
    chk("a_disp_sw", 32'(disp), 32'h1234);
    chk("a_start", 32'(start), 32'h0);
    sw = 16'h0042; btns(4'b1000);
    tick(); btns(4'b0000);
    chk("b_start", 32'(start), 32'h1);
    chk("b_phase", 32'(phase), 32'd2);
    chk("b_num2", 32'(num2), 32'h0042);
    chk("b_op", 32'(op), 32'h3);
    tick();
    chk("busy_phase", 32'(phase), 32'd3);
    chk("busy_start", 32'(start), 32'h0);
    tick();
    chk("show_phase", 32'(phase), 32'd4);
    chk("show_disp", 32'(disp), 32'hABCD);
    sw = 16'hFFFF; result_in = 16'h1111;
    tick();
    chk("show_hold_disp", 32'(disp), 32'hABCD);
    chk("show_hold_phase", 32'(phase), 32'd4);
    chk("show_hold_num1", 32'(num1), 32'h1234);
    btns(4'b0001);
    tick(); btns(4'b0000);
    chk("ret_phase", 32'(phase), 32'd0);
    chk("ret_disp", 32'(disp), 32'hFFFF);
    chk("ret_num2_held", 32'(num2), 32'h0042);

    // Priority fia over fla, buttons ignored in START/BUSY, timeout
    done = 1'b0;
    sw = 16'h0005; btns(4'b0001);
    tick(); btns(4'b0000);
    chk("p_num1", 32'(num1), 32'h0005);
    sw = 16'h0007; btns(4'b0101);
    tick();
    chk("p_op", 32'(op), 32'h2);
    chk("p_num2", 32'(num2), 32'h0007);
    chk("p_start", 32'(start), 32'h1);
    sw = 16'h0099; btns(4'b1111); // pressed in START
    tick();
    chk("ign_start_phase", 32'(phase), 32'd3);
    chk("ign_op", 32'(op), 32'h2);
    btns(4'b0010);
    tick();
    chk("busy2_phase", 32'(phase), 32'd3);
    tick();
    chk("busy3_phase", 32'(phase), 32'd3);
    tick(); btns(4'b0000);
    chk("busy4_phase", 32'(phase), 32'd3);
    chk("busy4_err", 32'(err), 32'h0);
    chk("busy_num1", 32'(num1), 32'h0005);
    chk("busy_num2", 32'(num2), 32'h0007);
    chk("busy_start_low", 32'(start), 32'h0);
    tick();
    chk("err_phase", 32'(phase), 32'd5);
    chk("err_flag", 32'(err), 32'h1);
    chk("err_disp", 32'(disp), 32'hEEEE);
    chk("err_op", 32'(op), 32'h2);
    tick();
    chk("err_hold", 32'(phase), 32'd5);
    sw = 16'h0033; btns(4'b0100);
    tick(); btns(4'b0000);
    chk("err_exit_phase", 32'(phase), 32'd0);
    chk("err_exit_flag", 32'(err), 32'h0);
    chk("err_exit_disp", 32'(disp), 32'h0033);

    // flm beats fla; async reset in BUSY
    sw = 16'h0011; btns(4'b0001);
    tick(); btns(4'b0000);
    sw = 16'h0022; btns(4'b0011);
    tick(); btns(4'b0000);
    chk("flm_op", 32'(op), 32'h1);
    tick();
    chk("rb_busy", 32'(phase), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("ar_phase", 32'(phase), 32'd0);
    chk("ar_num1", 32'(num1), 32'h0);
    chk("ar_num2", 32'(num2), 32'h0);
    chk("ar_op", 32'(op), 32'h0);
    chk("ar_start", 32'(start), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_start", 32'(start), 32'h0);
    chk("rel_phase", 32'(phase), 32'd0);
    tick();
    chk("rel2_start", 32'(start), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
